// File: rtl/fp_norm_shift_if.sv
// ---------------------------------------------------------------------------
// fp_norm_shift_if
// Handshake and data bundle between the FP adder mantissa stage, the
// sequential normalizer and the exponent-adjust stage.
//   in_valid / in_ready   : sum transfer into the normalizer
//   sum                   : raw mantissa result {carry, hidden, fraction}
//   out_valid / out_ready : result transfer out of the normalizer
//   mant                  : normalized fraction, hidden bit stripped
//   adjust                : {subtract flag, shift magnitude[4:0]}
//   zero                  : sum was exactly zero
//   rbit                  : bit dropped by a right shift
// The "slave" modport is the normalizer side.
// The "master" modport is the producer/consumer side.
// ---------------------------------------------------------------------------
interface fp_norm_shift_if #(
    parameter int FRAC_W = 23
);
    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W+1:0] sum;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W-1:0] mant;
    logic [5:0]        adjust;
    logic              zero;
    logic              rbit;

    modport master (
        output in_valid, sum, out_ready,
        input  in_ready, out_valid, mant, adjust, zero, rbit
    );

    modport slave (
        input  in_valid, sum, out_ready,
        output in_ready, out_valid, mant, adjust, zero, rbit
    );
endinterface

// File: rtl/fp_norm_shift.sv
// ---------------------------------------------------------------------------
// fp_norm_shift
// Sequential post-add normalizer for the single-precision FP adder.
// A raw FRAC_W+2 bit mantissa sum is normalized with one left shift per cycle.
// A carry-out is handled instead with a single right shift.
// The block reports the normalized fraction and a sign-magnitude exponent
// adjust code. It also reports a zero flag and the bit lost on a right shift.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any operation in flight)
//   bus  : fp_norm_shift_if.slave (sum in, normalized result out)
// ---------------------------------------------------------------------------
module fp_norm_shift #(
    parameter int FRAC_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    fp_norm_shift_if.slave      bus
);

    localparam int SH_W = FRAC_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [SH_W-1:0]   shreg_r;
    logic [4:0]        count_r;
    logic [FRAC_W-1:0] mant_r;
    logic [5:0]        adjust_r;
    logic              zero_r;
    logic              rbit_r;

    // Handshake flags decode directly from the registered state.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.mant      = mant_r;
    assign bus.adjust    = adjust_r;
    assign bus.zero      = zero_r;
    assign bus.rbit      = rbit_r;

    // Control FSM, shift register and registered result fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            shreg_r  <= {SH_W{1'b0}};
            count_r  <= 5'd0;
            mant_r   <= {FRAC_W{1'b0}};
            adjust_r <= 6'd0;
            zero_r   <= 1'b0;
            rbit_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg_r <= bus.sum;
                        count_r <= 5'd0;
                        state_r <= NORM;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                NORM: begin
                    // Priority: carry first, then zero, then hidden bit set.
                    // A zero sum must never enter the shift loop, so the zero
                    // test comes before the shift.
                    if (shreg_r[SH_W-1]) begin
                        mant_r   <= shreg_r[FRAC_W:1];
                        rbit_r   <= shreg_r[0];
                        adjust_r <= 6'b000001;
                        zero_r   <= 1'b0;
                        state_r  <= DONE;
                    end else if (shreg_r == {SH_W{1'b0}}) begin
                        mant_r   <= {FRAC_W{1'b0}};
                        rbit_r   <= 1'b0;
                        adjust_r <= 6'd0;
                        zero_r   <= 1'b1;
                        state_r  <= DONE;
                    end else if (shreg_r[FRAC_W]) begin
                        // An input that is already normalized gives adjust 6'b100000.
                        // The downstream stage reads that as -0.
                        mant_r   <= shreg_r[FRAC_W-1:0];
                        rbit_r   <= 1'b0;
                        adjust_r <= {1'b1, count_r};
                        zero_r   <= 1'b0;
                        state_r  <= DONE;
                    end else begin
                        shreg_r  <= {shreg_r[SH_W-2:0], 1'b0};
                        count_r  <= count_r + 5'd1;
                        state_r  <= NORM;
                    end
                end

                DONE: begin
                    // Result fields stay frozen until the consumer takes them.
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_shift.sv
// ---------------------------------------------------------------------------
// tb_fp_norm_shift
// Directed-vector bench for fp_norm_shift.
// The driver pushes the hand-computed expected result into a scoreboard
// queue. The expected output cycle is pushed with it.
// A monitor pops and compares each result as the DUT hands it out.
// ---------------------------------------------------------------------------
module tb_fp_norm_shift;

    localparam int FRAC_W = 23;

    typedef struct {
        logic [22:0] mant;
        logic [5:0]  adjust;
        logic        zero;
        logic        rbit;
        int          exp_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_norm_shift_if #(.FRAC_W(FRAC_W)) bus ();

    fp_norm_shift #(.FRAC_W(FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    bit   seen  = 1'b0;
    int   first_cyc;

    // Edge counter used to check result latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compares each result handed out against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc;
                end
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    check({e.name, "_mant"},    32'(bus.mant),   32'(e.mant));
                    check({e.name, "_adjust"},  32'(bus.adjust), 32'(e.adjust));
                    check({e.name, "_zero"},    32'(bus.zero),   32'(e.zero));
                    check({e.name, "_rbit"},    32'(bus.rbit),   32'(e.rbit));
                    check({e.name, "_latency"}, 32'(first_cyc),  32'(e.exp_cyc));
                    seen = 1'b0;
                end
            end
        end
    end

    // Offers one sum; called in the phase just after a rising edge.
    task automatic send(input logic [24:0] s, input bit track, input logic [22:0] m,
                        input logic [5:0] a, input logic z, input logic r,
                        input int n, input string nm);
        exp_t e;
        int w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            check({nm, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.sum      = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (track) begin
            e.mant = m; e.adjust = a; e.zero = z; e.rbit = r;
            e.exp_cyc = cyc + 1 + n;
            e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            seen = 1'b0;
        end
    endtask

    // Stops the run if some wait fails to end.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence.
    initial begin
        int w;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sum       = 25'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mant",      32'(bus.mant),      32'd0);
        check("rst_adjust",    32'(bus.adjust),    32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_rbit",      32'(bus.rbit),      32'd0);
        rst = 1'b0;

        // Directed vectors
        send(25'h0800000, 1'b1, 23'h000000, 6'b100000, 1'b0, 1'b0, 0,  "normalized");
        send(25'h1000001, 1'b1, 23'h000000, 6'b000001, 1'b0, 1'b1, 0,  "carry");
        send(25'h0200003, 1'b1, 23'h00000C, 6'b100010, 1'b0, 1'b0, 2,  "small_shift");
        send(25'h0000001, 1'b1, 23'h000000, 6'b110111, 1'b0, 1'b0, 23, "worst_case");
        send(25'h0000000, 1'b1, 23'h000000, 6'b000000, 1'b1, 1'b0, 0,  "zero");
        send(25'h1ABCDEF, 1'b1, 23'h55E6F7, 6'b000001, 1'b0, 1'b1, 0,  "carry_frac");
        send(25'h0FFFFFF, 1'b1, 23'h7FFFFF, 6'b100000, 1'b0, 1'b0, 0,  "all_ones");
        send(25'h0012345, 1'b1, 23'h11A280, 6'b100111, 1'b0, 1'b0, 7,  "shift7");
        drain();

        // Backpressure
        bus.out_ready = 1'b0;
        send(25'h0400001, 1'b1, 23'h000002, 6'b100001, 1'b0, 1'b0, 1, "bp");
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("bp_valid_wait", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.sum      = 25'($urandom());
            @(posedge clk); #1;
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_mant", 32'(bus.mant),      32'h000002);
            check("bp_hold_adj",  32'(bus.adjust),    32'h21);
            check("bp_hold_zero", 32'(bus.zero),      32'd0);
            check("bp_hold_rbit", 32'(bus.rbit),      32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        send(25'h1000000, 1'b1, 23'h000000, 6'b000001, 1'b0, 1'b0, 0, "after_bp");
        drain();

        // Reset during NORM
        send(25'h0000001, 1'b0, 23'h0, 6'h0, 1'b0, 1'b0, 0, "abort");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_mant",      32'(bus.mant),      32'd0);
        check("abort_adjust",    32'(bus.adjust),    32'd0);
        check("abort_zero",      32'(bus.zero),      32'd0);
        check("abort_rbit",      32'(bus.rbit),      32'd0);
        repeat (40) @(posedge clk);
        #1;
        send(25'h0100000, 1'b1, 23'h000000, 6'b100011, 1'b0, 1'b0, 3, "after_abort");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
